// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - round-robin obstacle scheduler with frame timing, round counting and manual debug select
// Plays enabled obstacle channels in turn for DUR_FRAMES frames each, separated by optional blank gaps.
module obstacle_scheduler #(
    parameter int N_OBS      = 16,
    parameter int SEL_W      = 4,
    parameter int DUR_FRAMES = 600,
    parameter int GAP_FRAMES = 60,
    parameter int MAX_ROUNDS = 3,
    parameter int CNT_W      = 10
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 game_on,
    input  logic                 vsync_in,
    input  logic [N_OBS*36-1:0]  obs_bus_in,
    input  logic [11:0]          rgb_bg_in,
    input  logic [N_OBS-1:0]     enable_mask,
    input  logic                 manual_mode,
    input  logic [SEL_W-1:0]     manual_sel,
    output logic [35:0]          obstacle_mux_out,
    output logic [SEL_W-1:0]     obs_select,
    output logic                 obs_start,
    output logic                 obs_active,
    output logic [7:0]           round_count,
    output logic                 round_done
);

    localparam int LP_SLOTS = 1 << SEL_W;
    localparam logic [CNT_W-1:0] LP_DUR_LAST = CNT_W'(DUR_FRAMES - 1);
    localparam logic [CNT_W-1:0] LP_GAP_LAST = CNT_W'((GAP_FRAMES > 0) ? GAP_FRAMES - 1 : 0);
    localparam logic [7:0]       LP_MAX      = 8'(MAX_ROUNDS);

    typedef enum logic [2:0] {ST_IDLE, ST_SELECT, ST_RUN, ST_GAP, ST_DONE} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_vsync_q;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [7:0]         r_round;
    logic               r_first;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_msel_q;
    logic [35:0]        r_mux;
    logic               r_start;
    logic               r_active;
    logic               r_done;

    logic               w_tick;
    logic               w_force_idle;
    logic [35:0]        w_bg;
    logic [35:0]        w_slice [LP_SLOTS];
    logic               w_found;
    logic               w_wrap;
    logic [SEL_W-1:0]   w_next_idx;
    logic [SEL_W-1:0]   w_sel_next;
    logic [7:0]         w_round_inc;
    logic               w_load;
    logic               w_round_wr;
    logic               w_cnt_clr;
    logic               w_cnt_en;
    logic               w_msel_ok;

    // Pad the slice table to the full select range so any select value indexes safely.
    genvar k;
    generate
        for (k = 0; k < LP_SLOTS; k++) begin : g_slice
            if (k < N_OBS) begin : g_real
                assign w_slice[k] = obs_bus_in[36*k +: 36];
            end else begin : g_pad
                assign w_slice[k] = '0;
            end
        end
    endgenerate

    assign w_tick       = vsync_in & ~r_vsync_q;
    assign w_force_idle = manual_mode | ~game_on;
    assign w_bg         = {24'd0, rgb_bg_in};
    assign w_round_inc  = (r_round == 8'hFF) ? r_round : r_round + 8'd1;
    assign w_msel_ok    = ({1'b0, manual_sel} < (SEL_W + 1)'(N_OBS));
    assign w_sel_next   = w_load ? w_next_idx : r_sel;

    // Rotating priority: pick the set bit with the smallest forward distance from the scan start.
    always_comb begin
        int v_start;
        int v_dist;
        int v_best;
        int v_best_dist;
        v_start     = r_first ? 0 : (int'(r_sel) + 1) % N_OBS;
        v_dist      = 0;
        v_best      = 0;
        v_best_dist = N_OBS;
        for (int i = 0; i < N_OBS; i++) begin
            v_dist = (i - v_start + N_OBS) % N_OBS;
            if (enable_mask[i] && (v_dist < v_best_dist)) begin
                v_best_dist = v_dist;
                v_best      = i;
            end
        end
        w_found    = (v_best_dist < N_OBS);
        w_next_idx = SEL_W'(v_best);
        w_wrap     = w_found && !r_first && (v_best <= int'(r_sel));
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_round_wr   = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        if (w_force_idle) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|enable_mask) w_next_state = ST_SELECT;
                end
                ST_SELECT: begin
                    if (!w_found) begin
                        w_next_state = ST_IDLE;
                    end else if (w_wrap && (LP_MAX != 8'd0) && (w_round_inc == LP_MAX)) begin
                        w_round_wr   = 1'b1;
                        w_next_state = ST_DONE;
                    end else begin
                        w_round_wr   = w_wrap;
                        w_load       = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_tick) begin
                        if (r_frame_cnt == LP_DUR_LAST) begin
                            w_cnt_clr    = 1'b1;
                            w_next_state = (GAP_FRAMES > 0) ? ST_GAP : ST_SELECT;
                        end else begin
                            w_cnt_en = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        if (r_frame_cnt == LP_GAP_LAST) begin
                            w_cnt_clr    = 1'b1;
                            w_next_state = ST_SELECT;
                        end else begin
                            w_cnt_en = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    w_next_state = ST_DONE;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Counters and scan-start bookkeeping; IDLE (or a forced return to it) wipes them.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_vsync_q   <= 1'b0;
            r_frame_cnt <= '0;
            r_round     <= 8'd0;
            r_first     <= 1'b1;
            r_msel_q    <= '0;
        end else begin
            r_vsync_q <= vsync_in;
            r_msel_q  <= manual_sel;
            if (w_force_idle || (r_state == ST_IDLE)) begin
                r_frame_cnt <= '0;
                r_round     <= 8'd0;
            end else begin
                if (w_cnt_clr) begin
                    r_frame_cnt <= '0;
                end else if (w_cnt_en) begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
                if (w_round_wr) r_round <= w_round_inc;
            end
            if (r_state == ST_IDLE) begin
                r_first <= 1'b1;
            end else if (w_load) begin
                r_first <= 1'b0;
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_mux    <= '0;
            r_sel    <= '0;
            r_start  <= 1'b0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else if (manual_mode) begin
            r_mux    <= w_msel_ok ? w_slice[manual_sel] : w_bg;
            r_sel    <= manual_sel;
            r_start  <= (manual_sel != r_msel_q);
            r_active <= w_msel_ok;
            r_done   <= 1'b0;
        end else begin
            r_mux    <= (w_next_state == ST_RUN) ? w_slice[w_sel_next] : w_bg;
            r_sel    <= w_sel_next;
            r_start  <= w_load;
            r_active <= (w_next_state == ST_RUN);
            r_done   <= (w_next_state == ST_DONE);
        end
    end

    assign obstacle_mux_out = r_mux;
    assign obs_select       = r_sel;
    assign obs_start        = r_start;
    assign obs_active       = r_active;
    assign round_count      = r_round;
    assign round_done       = r_done;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - directed table and sequence checks for obstacle_scheduler
module tb_obstacle_scheduler;

    logic          pclk = 1'b0;
    logic          rst;
    logic          game_on;
    logic          vsync_in;
    logic [143:0]  obs_bus;
    logic [11:0]   rgb_bg;
    logic [3:0]    mask;
    logic          manual_mode;
    logic [3:0]    manual_sel;

    logic [35:0]   a_mux, b_mux;
    logic [3:0]    a_sel, b_sel;
    logic          a_start, b_start, a_act, b_act, a_done, b_done;
    logic [7:0]    a_cnt, b_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int starts_a = 0;
    int starts_b = 0;
    logic [3:0] sel_log_a [$];

    always #5 pclk = ~pclk;

    obstacle_scheduler #(.N_OBS(4), .SEL_W(4), .DUR_FRAMES(3), .GAP_FRAMES(1), .MAX_ROUNDS(2), .CNT_W(10)) u_a (
        .pclk(pclk), .rst(rst), .game_on(game_on), .vsync_in(vsync_in), .obs_bus_in(obs_bus),
        .rgb_bg_in(rgb_bg), .enable_mask(mask), .manual_mode(manual_mode), .manual_sel(manual_sel),
        .obstacle_mux_out(a_mux), .obs_select(a_sel), .obs_start(a_start), .obs_active(a_act),
        .round_count(a_cnt), .round_done(a_done));

    obstacle_scheduler #(.N_OBS(4), .SEL_W(4), .DUR_FRAMES(3), .GAP_FRAMES(0), .MAX_ROUNDS(0), .CNT_W(10)) u_b (
        .pclk(pclk), .rst(rst), .game_on(game_on), .vsync_in(vsync_in), .obs_bus_in(obs_bus),
        .rgb_bg_in(rgb_bg), .enable_mask(mask), .manual_mode(manual_mode), .manual_sel(manual_sel),
        .obstacle_mux_out(b_mux), .obs_select(b_sel), .obs_start(b_start), .obs_active(b_act),
        .round_count(b_cnt), .round_done(b_done));

    always @(negedge pclk) begin
        if (!rst) begin
            if (a_start) begin
                starts_a++;
                sel_log_a.push_back(a_sel);
            end
            if (b_start) starts_b++;
        end
    end

    function automatic logic [35:0] slice_val(input int k);
        return {12'(16'h100 + k), 12'(16'h200 + k), 12'(16'h300 + k)};
    endfunction

    function automatic logic [35:0] bg_val(input logic [11:0] c);
        return {24'd0, c};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic tick();
        vsync_in = 1'b1;
        step();
        vsync_in = 1'b0;
        step();
        step();
    endtask

    typedef struct {
        logic        mm;
        logic [3:0]  sel;
        logic        go;
        logic [35:0] e_mux;
        logic [3:0]  e_sel;
        logic        e_act;
        logic        e_st;
    } vec_t;

    vec_t tbl [10];
    int   sa, sb, qn;

    initial begin
        rst = 1'b1; game_on = 1'b0; vsync_in = 1'b0; mask = 4'b0000;
        manual_mode = 1'b0; manual_sel = 4'd0; rgb_bg = 12'hABC;
        for (int k = 0; k < 4; k++) obs_bus[36*k +: 36] = slice_val(k);

        step(); step();
        chk("reset_outputs", {a_mux, a_sel, a_start, a_act, a_cnt, a_done}, 64'd0);
        rst = 1'b0;
        step();
        chk("idle_bg", {a_mux, a_act}, {bg_val(12'hABC), 1'b0});

        // Main rotation: mask 1010, two rounds to DONE after 16 ticks.
        mask = 4'b1010;
        sa = starts_a; qn = sel_log_a.size();
        game_on = 1'b1;
        step();
        chk("select_cycle_inactive", {a_act, a_start}, 2'b00);
        step();
        chk("first_run_entry", {a_start, a_sel, a_act, a_mux}, {1'b1, 4'd1, 1'b1, slice_val(1)});
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t == 15) chk("before_16th_tick", {a_done, a_cnt}, {1'b0, 8'd1});
        end
        chk("done_after_16", {a_done, a_cnt, a_act, a_mux}, {1'b1, 8'd2, 1'b0, bg_val(12'hABC)});
        for (int t = 17; t <= 20; t++) tick();
        chk("done_holds", {a_done, a_cnt}, {1'b1, 8'd2});
        chk("start_pulses", 64'(starts_a - sa), 64'd4);
        if (sel_log_a.size() >= qn + 4) begin
            chk("sel_seq0", 64'(sel_log_a[qn]),     64'd1);
            chk("sel_seq1", 64'(sel_log_a[qn + 1]), 64'd3);
            chk("sel_seq2", 64'(sel_log_a[qn + 2]), 64'd1);
            chk("sel_seq3", 64'(sel_log_a[qn + 3]), 64'd3);
        end else begin
            chk("sel_seq_len", 64'(sel_log_a.size() - qn), 64'd4);
        end
        game_on = 1'b0;
        step();
        chk("done_to_idle", {a_done, a_cnt}, {1'b0, 8'd0});
        step();

        // Drop game_on mid-RUN of the second obstacle, on a tick edge.
        game_on = 1'b1;
        step(); step();
        for (int t = 0; t < 4; t++) tick();
        chk("second_obstacle_run", {a_act, a_sel}, {1'b1, 4'd3});
        rgb_bg = 12'h123;
        vsync_in = 1'b1; game_on = 1'b0;
        step();
        vsync_in = 1'b0;
        chk("drop_game_on", {a_act, a_cnt, a_mux, a_sel}, {1'b0, 8'd0, bg_val(12'h123), 4'd3});
        step();

        // Empty mask never leaves IDLE.
        mask = 4'b0000;
        sa = starts_a;
        game_on = 1'b1;
        step(); step(); step();
        tick();
        chk("mask_zero_idle", {a_act, a_mux}, {1'b0, bg_val(12'h123)});
        chk("mask_zero_no_start", 64'(starts_a - sa), 64'd0);
        game_on = 1'b0;
        mask = 4'b1010;
        rgb_bg = 12'hABC;
        step();

        tbl[0] = '{1'b1, 4'd0, 1'b0, slice_val(0), 4'd0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 4'd2, 1'b0, slice_val(2), 4'd2, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 4'd2, 1'b0, slice_val(2), 4'd2, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 4'd5, 1'b0, bg_val(12'hABC), 4'd5, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 4'd5, 1'b0, bg_val(12'hABC), 4'd5, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 4'd3, 1'b1, slice_val(3), 4'd3, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 4'd1, 1'b1, slice_val(1), 4'd1, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 4'd1, 1'b1, bg_val(12'hABC), 4'd1, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 4'd1, 1'b1, slice_val(1), 4'd1, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 4'd1, 1'b0, bg_val(12'hABC), 4'd1, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            manual_mode = tbl[i].mm;
            manual_sel  = tbl[i].sel;
            game_on     = tbl[i].go;
            step();
            chk($sformatf("manual_vec%0d", i), {a_mux, a_sel, a_act, a_start, a_cnt, a_done},
                {tbl[i].e_mux, tbl[i].e_sel, tbl[i].e_act, tbl[i].e_st, 8'd0, 1'b0});
        end
        step();

        // Single channel, no gap, endless rounds (instance b).
        mask = 4'b0100;
        step();
        sb = starts_b;
        game_on = 1'b1;
        step(); step();
        chk("b_first_run", {b_start, b_sel, b_act}, {1'b1, 4'd2, 1'b1});
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 11) chk("b_count_11", {b_cnt, b_done}, {8'd3, 1'b0});
        end
        chk("b_count_12", {b_cnt, b_done, b_sel, b_act}, {8'd4, 1'b0, 4'd2, 1'b1});
        chk("b_start_pulses", 64'(starts_b - sb), 64'd5);

        // Asynchronous reset in the middle of RUN.
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset", {b_mux, b_sel, b_start, b_act, b_cnt, b_done}, 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_reset_select", b_act, 1'b0);
        step();
        chk("post_reset_run", {b_act, b_start, b_sel}, {1'b1, 1'b1, 4'd2});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Parametrised replacement for the switch-driven 16-to-1 obstacle multiplexer. It owns N_OBS obstacle channels and plays the enabled ones in round-robin order, each for a fixed number of video frames, with an optional blank gap between obstacles. It counts completed rounds and flags round completion to the game logic. It sits between the obstacle generators and collision detection / HP drawing, and keeps the old manual switch selection as a debug mode.

## Interface
Parameters:
- N_OBS, 16: number of obstacle channels (2..16).
- SEL_W, 4: select width; must satisfy 2^SEL_W ≥ N_OBS.
- DUR_FRAMES, 600: frames each obstacle stays active (≥1).
- GAP_FRAMES, 60: blank frames between obstacles; 0 means no gap.
- MAX_ROUNDS, 3: completed rounds before DONE; 0 means play forever.
- CNT_W, 10: frame counter width; must hold max(DUR_FRAMES, GAP_FRAMES).

Ports:
- pclk  in  1  pixel clock, the only clock.
- rst  in  1  asynchronous, active-high reset.
- game_on  in  1  level; high while a game is in progress (driven from play_selected).
- vsync_in  in  1  vsync from the timing chain; its rising edge is the frame tick.
- obs_bus_in  in  N_OBS*36  channel k occupies bits [36k+35:36k], packed as {x[11:0], y[11:0], rgb[11:0]}.
- rgb_bg_in  in  12  background pixel, used whenever no obstacle is active.
- enable_mask  in  N_OBS  bit k set means channel k takes part in the rotation.
- manual_mode  in  1  debug bypass.
- manual_sel  in  SEL_W  channel selected in manual mode.
- obstacle_mux_out  out  36  {x, y, rgb} of the active channel; registered.
- obs_select  out  SEL_W  index of the active channel.
- obs_start  out  1  one-cycle pulse when a channel becomes active; restarts that generator.
- obs_active  out  1  high while an obstacle is active (RUN state, or manual mode).
- round_count  out  8  number of completed rounds; saturates at 255.
- round_done  out  1  high in DONE.

## Operation
- Frame tick: vsync_in is registered once; tick = vsync_in & ~vsync_q.
- FSM states: IDLE, SELECT, RUN, GAP, DONE.
- IDLE:
  - Output is bg: {12'd0, 12'd0, rgb_bg_in}.
  - Counters are cleared.
  - Go to SELECT when game_on=1 and enable_mask≠0. An all-zero mask keeps the block in IDLE.
- SELECT:
  - Next channel = first set mask bit scanning from cur+1 upward, wrapping past N_OBS-1 to 0.
  - On the first SELECT after IDLE, the scan starts at index 0, inclusive.
  - A scan that wraps (next ≤ cur, excluding the first selection) completes a round: round_count+1.
  - If MAX_ROUNDS≠0 and the new round_count equals MAX_ROUNDS, go to DONE. Otherwise load obs_select, clear the frame counter and go to RUN.
  - A single enabled channel wraps onto itself; each pass counts as one round.
- RUN:
  - Output is the selected channel's 36-bit slice; obs_active=1.
  - The frame counter increments on each tick.
  - On the tick where counter = DUR_FRAMES-1: go to GAP (GAP_FRAMES>0) or SELECT.
- GAP:
  - Output is bg; obs_active=0.
  - Counter cleared on entry; leave for SELECT on the tick where counter = GAP_FRAMES-1.
- DONE:
  - Output is bg; round_done=1.
  - Hold until game_on=0, then go to IDLE.
- enable_mask is sampled only in SELECT. Mask changes during RUN take effect at the next selection.
- Mask cleared to zero while playing: SELECT finds nothing and goes to IDLE. round_count is held until IDLE clears it.
- game_on=0 in any state: go to IDLE on the next edge and clear round_count. This takes priority over a simultaneous tick.
- Manual mode (manual_mode=1):
  - FSM is forced to IDLE with counters frozen at 0.
  - Output = slice[manual_sel] and obs_select=manual_sel; obs_active=1.
  - manual_sel ≥ N_OBS gives bg with obs_active=0.
  - obs_start pulses once whenever manual_sel changes.

## Timing
- Reset values: state IDLE; every output 0; vsync_q=0.
- obstacle_mux_out is registered: one cycle of latency from obs_bus_in / rgb_bg_in. The integrator adds one stage to the sync delay line.
- game_on rising seen at edge t: SELECT at t+1, RUN at t+2. obs_start=1 during the first RUN cycle only; obs_select is valid from that same cycle.
- SELECT always lasts exactly one cycle.
- RUN lasts exactly DUR_FRAMES ticks; GAP lasts exactly GAP_FRAMES ticks.
- obs_select only changes on the SELECT→RUN transition or in manual mode.
- Reset asserted mid-RUN: all outputs are 0 immediately, asynchronously.

## Test plan
- N_OBS=4, DUR=3, GAP=1, MAX_ROUNDS=2, mask=4'b1010, game_on held high, 20 vsync pulses:
  - Required: obs_select sequence 1,3,1,3.
  - Required: obs_start pulses at each RUN entry.
  - Required: round_done=1 after the 16th tick, with round_count=2.
- Same setup, drop game_on mid-RUN of the second obstacle, coincident with a tick:
  - Required: IDLE on the next cycle; round_count=0; output = {0,0,rgb_bg_in}.
- mask=0, game_on=1: block stays in IDLE; obs_active=0; no obs_start.
- Manual mode, manual_sel 2 then 5 (N_OBS=4):
  - Required: output = slice 2 one cycle after selection, with obs_start pulsing once.
  - Required: for manual_sel=5, output is bg with obs_active=0.
- GAP=0, mask=4'b0100, MAX_ROUNDS=0, 12 ticks:
  - Required: obs_select stays at 2 and obs_start pulses every 3 ticks.
  - Required: round_count reaches 4 with no DONE.
- Assert rst while in RUN: all outputs go to 0 asynchronously. After release with game_on=1, RUN is re-entered 2 cycles later.
